// File: rtl/vend_session_ctrl.sv
// vend_session_ctrl: vending session sequencer.
// Credit, item select, dispense and change handshakes.
module vend_session_ctrl #(
  parameter int CREDIT_W   = 6,
  parameter int MAX_CREDIT = 40,
  parameter int PRICE0     = 10,
  parameter int PRICE1     = 15,
  parameter int PRICE2     = 17,
  parameter int PRICE3     = 20,
  parameter int IDLE_TMO   = 1000,
  parameter int DISP_TMO   = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [3:0]          coin_value,
  output logic                coin_accept,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  output logic                sel_ready,
  input  logic                cancel,
  output logic                disp_req,
  output logic [1:0]          disp_item,
  input  logic                disp_done,
  output logic                chg_valid,
  output logic [CREDIT_W-1:0] chg_amount,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                err_funds,
  output logic                err_disp
);

  localparam int IW = (IDLE_TMO > 2) ? $clog2(IDLE_TMO) : 1;
  localparam int DW = (DISP_TMO > 2) ? $clog2(DISP_TMO) : 1;
  localparam logic [CREDIT_W:0] MAXC = (CREDIT_W+1)'(MAX_CREDIT);

  typedef enum logic [1:0] {
    S_IDLE, S_CREDIT, S_DISP, S_CHANGE
  } state_t;

  state_t              r_state, w_state;
  logic [CREDIT_W-1:0] r_credit, w_credit;
  logic [1:0]          r_item, w_item;
  logic [IW-1:0]       r_icnt, w_icnt;
  logic [DW-1:0]       r_dcnt, w_dcnt;
  logic                r_acc, w_acc, r_rej, w_rej;
  logic                r_ef, w_ef, r_ed, w_ed;
  logic                r_rdy, w_rdy, r_req, w_req;
  logic                r_chgv, w_chgv;
  logic [CREDIT_W-1:0] r_chga, w_chga;

  logic                w_coin, w_act, w_afford;
  logic [CREDIT_W-1:0] w_price, w_refund;
  logic [CREDIT_W:0]   w_sum, w_ref;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] i);
    case (i)
      2'd0:    price_of = CREDIT_W'(PRICE0);
      2'd1:    price_of = CREDIT_W'(PRICE1);
      2'd2:    price_of = CREDIT_W'(PRICE2);
      default: price_of = CREDIT_W'(PRICE3);
    endcase
  endfunction

  // Shared arithmetic: coin sum, select price, saturated refund.
  always_comb begin
    w_coin   = coin_valid && (coin_value != 4'd0);
    w_act    = coin_valid || sel_valid || cancel;
    w_sum    = {1'b0, r_credit}
             + {{(CREDIT_W-3){1'b0}}, coin_value};
    w_price  = price_of(sel_item);
    w_afford = (r_credit >= w_price);
    w_ref    = {1'b0, r_credit} + {1'b0, price_of(r_item)};
    w_refund = (w_ref > MAXC) ? MAXC[CREDIT_W-1:0]
                              : w_ref[CREDIT_W-1:0];
  end

  // Next-state and next-output decode; outputs follow next state.
  always_comb begin
    w_state  = r_state;
    w_credit = r_credit;
    w_item   = r_item;
    w_icnt   = r_icnt;
    w_dcnt   = r_dcnt;
    w_acc    = 1'b0;
    w_rej    = 1'b0;
    w_ef     = 1'b0;
    w_ed     = 1'b0;
    unique case (r_state)
      S_IDLE, S_CREDIT: begin
        if (cancel && r_state == S_CREDIT) begin
          w_state = S_CHANGE;
          w_rej   = w_coin;
          w_icnt  = '0;
        end else if (sel_valid && w_afford) begin
          w_credit = r_credit - w_price;
          w_item   = sel_item;
          w_state  = S_DISP;
          w_dcnt   = '0;
          w_rej    = w_coin;
          w_icnt   = '0;
        end else begin
          w_ef = sel_valid;
          if (w_coin) begin
            if (w_sum <= MAXC) begin
              w_credit = w_sum[CREDIT_W-1:0];
              w_acc    = 1'b1;
              w_state  = S_CREDIT;
            end else begin
              w_rej = 1'b1;
            end
          end
          if (w_act) begin
            w_icnt = '0;
          end else if (r_state == S_CREDIT) begin
            if (r_icnt == IW'(IDLE_TMO-1)) begin
              w_state = S_CHANGE;
              w_icnt  = '0;
            end else begin
              w_icnt = r_icnt + 1'b1;
            end
          end
        end
      end
      S_DISP: begin
        w_rej = w_coin;
        if (disp_done) begin
          w_state = (r_credit != '0) ? S_CHANGE : S_IDLE;
        end else if (r_dcnt == DW'(DISP_TMO-1)) begin
          w_ed     = 1'b1;
          w_credit = w_refund;
          w_state  = S_CHANGE;
        end else begin
          w_dcnt = r_dcnt + 1'b1;
        end
      end
      S_CHANGE: begin
        w_rej = w_coin;
        if (chg_ack) begin
          w_credit = '0;
          w_state  = S_IDLE;
        end
      end
    endcase
    w_rdy  = (w_state == S_IDLE) || (w_state == S_CREDIT);
    w_req  = (w_state == S_DISP);
    w_chgv = (w_state == S_CHANGE);
    w_chga = w_chgv ? w_credit : '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_item   <= '0;
      r_icnt   <= '0;
      r_dcnt   <= '0;
      r_acc    <= 1'b0;
      r_rej    <= 1'b0;
      r_ef     <= 1'b0;
      r_ed     <= 1'b0;
      r_rdy    <= 1'b0;
      r_req    <= 1'b0;
      r_chgv   <= 1'b0;
      r_chga   <= '0;
    end else begin
      r_state  <= w_state;
      r_credit <= w_credit;
      r_item   <= w_item;
      r_icnt   <= w_icnt;
      r_dcnt   <= w_dcnt;
      r_acc    <= w_acc;
      r_rej    <= w_rej;
      r_ef     <= w_ef;
      r_ed     <= w_ed;
      r_rdy    <= w_rdy;
      r_req    <= w_req;
      r_chgv   <= w_chgv;
      r_chga   <= w_chga;
    end
  end

  assign coin_accept = r_acc;
  assign coin_reject = r_rej;
  assign sel_ready   = r_rdy;
  assign disp_req    = r_req;
  assign disp_item   = r_item;
  assign chg_valid   = r_chgv;
  assign chg_amount  = r_chga;
  assign credit      = r_credit;
  assign err_funds   = r_ef;
  assign err_disp    = r_ed;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// tb_vend_session_ctrl: directed scoreboard bench
// for the vending session sequencer.
module tb_vend_session_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_value = 4'd0;
  logic       coin_accept, coin_reject;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       sel_ready;
  logic       cancel = 1'b0;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       disp_done = 1'b0;
  logic       chg_valid;
  logic [5:0] chg_amount;
  logic       chg_ack = 1'b0;
  logic [5:0] credit;
  logic       err_funds, err_disp;

  vend_session_ctrl #(
    .IDLE_TMO(8),
    .DISP_TMO(4)
  ) dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .coin_accept(coin_accept), .coin_reject(coin_reject),
    .sel_valid(sel_valid), .sel_item(sel_item),
    .sel_ready(sel_ready), .cancel(cancel),
    .disp_req(disp_req), .disp_item(disp_item),
    .disp_done(disp_done), .chg_valid(chg_valid),
    .chg_amount(chg_amount), .chg_ack(chg_ack),
    .credit(credit), .err_funds(err_funds),
    .err_disp(err_disp)
  );

  always #5 clk = ~clk;

  localparam int CR = 0, ACC = 1, REJ = 2, RDY = 3;
  localparam int REQ = 4, ITM = 5, CHV = 6, CHA = 7;
  localparam int EF = 8, ED = 9;

  typedef struct {
    string tag;
    int    sig;
    int    val;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total = 0;

  function automatic logic [31:0] obs(input int s);
    case (s)
      CR:  obs = {26'd0, credit};
      ACC: obs = {31'd0, coin_accept};
      REJ: obs = {31'd0, coin_reject};
      RDY: obs = {31'd0, sel_ready};
      REQ: obs = {31'd0, disp_req};
      ITM: obs = {30'd0, disp_item};
      CHV: obs = {31'd0, chg_valid};
      CHA: obs = {26'd0, chg_amount};
      EF:  obs = {31'd0, err_funds};
      default: obs = {31'd0, err_disp};
    endcase
  endfunction

  task automatic ex(input string tag, input int s, input int v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    logic [31:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sig);
      total++;
      assert (o === 32'(e.val)) passed++;
      else $error("FAIL %s: got %0d, want %0d",
                  e.tag, o, e.val);
    end
  endtask

  task automatic drive(input int cv, input int val,
                       input int sv, input int it,
                       input int cn, input int dd,
                       input int ak);
    coin_valid = (cv != 0);
    coin_value = 4'(val);
    sel_valid  = (sv != 0);
    sel_item   = 2'(it);
    cancel     = (cn != 0);
    disp_done  = (dd != 0);
    chg_ack    = (ak != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic coin(input string tag, input int v,
                      input int acc, input int cr);
    drive(1, v, 0, 0, 0, 0, 0);
    ex(tag, ACC, acc);
    ex(tag, REJ, 1 - acc);
    ex(tag, CR, cr);
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    ex("rst_cr", CR, 0);
    ex("rst_rdy", RDY, 0);
    ex("rst_req", REQ, 0);
    ex("rst_chv", CHV, 0);
    check_now();
    reset = 1'b0;
    idle(); ex("idle_rdy", RDY, 1); tick();

    coin("t1_c10", 10, 1, 10);
    coin("t1_c5", 5, 1, 15);
    drive(0, 0, 1, 1, 0, 0, 0);
    ex("t1_sel_cr", CR, 0);
    ex("t1_req", REQ, 1);
    ex("t1_item", ITM, 1);
    ex("t1_rdy", RDY, 0);
    tick();
    idle(); ex("t1_hold", REQ, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    ex("t1_done_req", REQ, 0);
    ex("t1_done_chv", CHV, 0);
    ex("t1_done_rdy", RDY, 1);
    tick();

    coin("t2_c10a", 10, 1, 10);
    coin("t2_c10b", 10, 1, 20);
    drive(0, 0, 1, 2, 0, 0, 0);
    ex("t2_sel_cr", CR, 3);
    ex("t2_item", ITM, 2);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    ex("t2_chv", CHV, 1);
    ex("t2_cha", CHA, 3);
    ex("t2_req", REQ, 0);
    tick();
    idle(); ex("t2_chv_hold", CHV, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    ex("t2_ack_chv", CHV, 0);
    ex("t2_ack_cr", CR, 0);
    tick();

    coin("t3_c5", 5, 1, 5);
    drive(0, 0, 1, 3, 0, 0, 0);
    ex("t3_ef", EF, 1);
    ex("t3_cr", CR, 5);
    ex("t3_req", REQ, 0);
    tick();
    idle(); ex("t3_ef_pulse", EF, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    ex("t3_cn_chv", CHV, 1);
    ex("t3_cn_cha", CHA, 5);
    tick();
    coin("t3_chg_coin", 5, 0, 5);
    drive(0, 0, 0, 0, 0, 0, 1);
    ex("t3_ack_cr", CR, 0); tick();

    coin("t4_a", 10, 1, 10);
    coin("t4_b", 10, 1, 20);
    coin("t4_c", 10, 1, 30);
    coin("t4_d", 5, 1, 35);
    coin("t4_over", 10, 0, 35);
    drive(1, 5, 1, 0, 0, 0, 0);
    ex("t4_sel_req", REQ, 1);
    ex("t4_sel_item", ITM, 0);
    ex("t4_sel_rej", REJ, 1);
    ex("t4_sel_acc", ACC, 0);
    ex("t4_sel_cr", CR, 25);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    ex("t4_cha", CHA, 25); tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    ex("t4_ack_cr", CR, 0); tick();

    coin("t5_a", 10, 1, 10);
    coin("t5_b", 10, 1, 20);
    drive(0, 0, 1, 3, 0, 0, 0);
    ex("t5_sel_cr", CR, 0);
    ex("t5_item", ITM, 3);
    tick();
    for (int i = 1; i < 4; i++) begin
      idle();
      ex("t5_wait_req", REQ, 1);
      ex("t5_wait_ed", ED, 0);
      tick();
    end
    idle();
    ex("t5_ed", ED, 1);
    ex("t5_req", REQ, 0);
    ex("t5_chv", CHV, 1);
    ex("t5_cha", CHA, 20);
    ex("t5_cr", CR, 20);
    tick();
    idle(); ex("t5_ed_pulse", ED, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    ex("t5_ack_cr", CR, 0); tick();

    coin("t6_c7", 7, 1, 7);
    for (int i = 1; i < 8; i++) begin
      idle(); ex("t6_wait_chv", CHV, 0); tick();
    end
    idle();
    ex("t6_tmo_chv", CHV, 1);
    ex("t6_tmo_cha", CHA, 7);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    ex("t6_ack_cr", CR, 0); tick();

    coin("t7_a", 15, 1, 15);
    coin("t7_b", 15, 1, 30);
    coin("t7_max", 10, 1, 40);
    coin("t7_over1", 1, 0, 40);
    drive(0, 0, 1, 0, 0, 0, 0);
    ex("t7_sel_cr", CR, 30);
    ex("t7_req", REQ, 1);
    tick();
    idle();
    reset = 1'b1;
    #1;
    ex("mid_rst_cr", CR, 0);
    ex("mid_rst_req", REQ, 0);
    ex("mid_rst_item", ITM, 0);
    ex("mid_rst_chv", CHV, 0);
    ex("mid_rst_rdy", RDY, 0);
    check_now();
    #1;
    reset = 1'b0;
    ex("post_rst_rdy", RDY, 1);
    ex("post_rst_cr", CR, 0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
